// File: rtl/rom_image_loader.sv
// Buffers data_io download bytes in a small FIFO and commits one byte per SDRAM slot,
// mapping each image index to a base address and holding the core in reset until done.
module rom_image_loader #(
  parameter int unsigned                  ADDR_W      = 25,
  parameter int unsigned                  DEPTH       = 8,
  parameter int unsigned                  NUM_SLOTS   = 4,
  parameter logic [NUM_SLOTS*ADDR_W-1:0]  SLOT_BASE   = {25'h0, 25'h0, 25'h28000, 25'h80000},
  parameter int unsigned                  SPAN_W      = 17,
  parameter logic [7:0]                   SKIP_INDEX  = 8'hff,
  parameter int unsigned                  HOLD_CYCLES = 4095
) (
  input  logic              clk_48m,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [ADDR_W-1:0] ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic              mem_sync,
  output logic              loader_we,
  output logic [ADDR_W-1:0] loader_addr,
  output logic [7:0]        loader_data,
  output logic              busy,
  output logic              done,
  output logic              core_reset_req,
  output logic              overflow,
  output logic              range_err,
  output logic [ADDR_W-1:0] bytes_written
);

  localparam int unsigned      PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0]   CNT_FULL  = (PTR_W + 1)'(DEPTH);
  localparam logic [15:0]      HOLD_INIT = 16'(HOLD_CYCLES);

  logic [ADDR_W+7:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [PTR_W:0]    r_count;
  logic              r_dl_prev;
  logic              r_busy_d;
  logic              r_done;
  logic              r_we;
  logic              r_ovf;
  logic              r_rng;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_data;
  logic [ADDR_W-1:0] r_bytes;
  logic [15:0]       r_hold;

  logic              w_qual;
  logic              w_out_of_range;
  logic              w_full;
  logic              w_pop;
  logic              w_push;
  logic              w_drop_ovf;
  logic              w_drop_rng;
  logic              w_dl_rise;
  logic              w_busy;
  logic [ADDR_W-1:0] w_base;
  logic [ADDR_W-1:0] w_waddr;
  logic [ADDR_W+7:0] w_head;

  // Indices past the slot table fall through to the last slot.
  always_comb begin
    w_base = SLOT_BASE[(NUM_SLOTS-1)*ADDR_W +: ADDR_W];
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (ioctl_index == 8'(i)) w_base = SLOT_BASE[i*ADDR_W +: ADDR_W];
    end
  end

  assign w_waddr        = w_base + ioctl_addr;
  assign w_qual         = ioctl_wr & ioctl_download & (ioctl_index != SKIP_INDEX);
  assign w_out_of_range = (ioctl_addr >> SPAN_W) != '0;
  assign w_full         = (r_count == CNT_FULL);
  assign w_pop          = mem_sync & (r_count != '0);
  assign w_drop_rng     = w_qual & w_out_of_range;
  assign w_drop_ovf     = w_qual & ~w_out_of_range & w_full & ~w_pop;
  assign w_push         = w_qual & ~w_out_of_range & (~w_full | w_pop);
  assign w_dl_rise      = ioctl_download & ~r_dl_prev;
  assign w_busy         = ioctl_download | (r_count != '0) | r_we;
  assign w_head         = r_mem[r_rptr];

  always_ff @(posedge clk_48m) begin
    if (w_push) r_mem[r_wptr] <= {w_waddr, ioctl_dout};
  end

  always_ff @(posedge clk_48m) begin
    if (reset) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_dl_prev <= 1'b0;
      r_busy_d  <= 1'b0;
      r_done    <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
      r_ovf     <= 1'b0;
      r_rng     <= 1'b0;
      r_bytes   <= '0;
    end else begin
      r_dl_prev <= ioctl_download;
      r_busy_d  <= w_busy;
      r_done    <= r_busy_d & ~w_busy;

      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      if (mem_sync) r_we <= w_pop;
      if (w_pop) begin
        r_addr <= w_head[ADDR_W+7:8];
        r_data <= w_head[7:0];
      end

      // A drop in the same cycle as a new download belongs to the new download.
      r_ovf <= (r_ovf & ~w_dl_rise) | w_drop_ovf;
      r_rng <= (r_rng & ~w_dl_rise) | w_drop_rng;

      if (w_dl_rise)  r_bytes <= '0;
      else if (w_pop) r_bytes <= r_bytes + 1'b1;
    end
  end

  // Reloading while busy is still visible one cycle later stretches the release by one cycle.
  always_ff @(posedge clk_48m) begin
    if (reset)                    r_hold <= '0;
    else if (w_busy | r_busy_d)   r_hold <= HOLD_INIT;
    else if (r_hold != '0)        r_hold <= r_hold - 16'd1;
  end

  assign loader_we      = r_we;
  assign loader_addr    = r_addr;
  assign loader_data    = r_data;
  assign busy           = w_busy;
  assign done           = r_done;
  assign core_reset_req = w_busy | (r_hold != '0);
  assign overflow       = r_ovf;
  assign range_err      = r_rng;
  assign bytes_written  = r_bytes;

endmodule

// File: tb/tb_rom_image_loader.sv
// Directed bench for rom_image_loader: slot map, FIFO full/overflow, range drop,
// reset-hold release timing and reset during a drain.
module tb_rom_image_loader;

  logic        clk_48m = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        mem_sync;
  logic        loader_we;
  logic [24:0] loader_addr;
  logic [7:0]  loader_data;
  logic        busy;
  logic        done;
  logic        core_reset_req;
  logic        overflow;
  logic        range_err;
  logic [24:0] bytes_written;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #10 clk_48m = ~clk_48m;

  rom_image_loader #(
    .ADDR_W      (25),
    .DEPTH       (8),
    .NUM_SLOTS   (4),
    .SLOT_BASE   ({25'h0, 25'h0, 25'h28000, 25'h80000}),
    .SPAN_W      (17),
    .SKIP_INDEX  (8'hff),
    .HOLD_CYCLES (4095)
  ) dut (
    .clk_48m        (clk_48m),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .mem_sync       (mem_sync),
    .loader_we      (loader_we),
    .loader_addr    (loader_addr),
    .loader_data    (loader_data),
    .busy           (busy),
    .done           (done),
    .core_reset_req (core_reset_req),
    .overflow       (overflow),
    .range_err      (range_err),
    .bytes_written  (bytes_written)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic s, input logic w, input logic [24:0] a, input logic [7:0] d);
    mem_sync   = s;
    ioctl_wr   = w;
    ioctl_addr = a;
    ioctl_dout = d;
    @(posedge clk_48m);
    #1;
    mem_sync = 1'b0;
    ioctl_wr = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 25'h0, 8'h0);
  endtask

  task automatic sync();
    step(1'b1, 1'b0, 25'h0, 8'h0);
  endtask

  initial begin
    int unsigned k;
    reset = 1'b1; ioctl_download = 1'b0; ioctl_index = 8'h0;
    ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_dout = '0; mem_sync = 1'b0;
    idle(); idle();
    chk("rst_we",    32'(loader_we), 32'h0);
    chk("rst_addr",  32'(loader_addr), 32'h0);
    chk("rst_data",  32'(loader_data), 32'h0);
    chk("rst_busy",  32'(busy), 32'h0);
    chk("rst_done",  32'(done), 32'h0);
    chk("rst_ovf",   32'(overflow), 32'h0);
    chk("rst_rng",   32'(range_err), 32'h0);
    chk("rst_bytes", 32'(bytes_written), 32'h0);
    chk("rst_crr",   32'(core_reset_req), 32'h0);
    reset = 1'b0;
    idle();

    // Single byte and reset-hold release
    ioctl_download = 1'b1; ioctl_index = 8'd0;
    step(1'b0, 1'b1, 25'h12, 8'hA5);
    chk("sb_busy", 32'(busy), 32'h1);
    chk("sb_we_before_sync", 32'(loader_we), 32'h0);
    ioctl_download = 1'b0;
    sync();
    chk("sb_we",    32'(loader_we), 32'h1);
    chk("sb_addr",  32'(loader_addr), 32'h80012);
    chk("sb_data",  32'(loader_data), 32'hA5);
    chk("sb_bytes", 32'(bytes_written), 32'h1);
    idle(); idle(); idle();
    chk("sb_we_held", 32'(loader_we), 32'h1);
    sync();
    chk("sb_we_drop", 32'(loader_we), 32'h0);
    chk("sb_busy_low", 32'(busy), 32'h0);
    chk("sb_done_not_yet", 32'(done), 32'h0);
    chk("sb_crr_held", 32'(core_reset_req), 32'h1);
    k = 0;
    while (core_reset_req && k < 5000) begin
      idle();
      k++;
      if (k == 1) chk("sb_done_pulse", 32'(done), 32'h1);
      if (k == 2) chk("sb_done_clear", 32'(done), 32'h0);
    end
    chk("sb_release_cycles", k, 32'd4096);
    chk("sb_bytes_kept", 32'(bytes_written), 32'h1);

    // Slot map
    ioctl_download = 1'b1; ioctl_index = 8'd1;
    step(1'b0, 1'b1, 25'h0, 8'h11);
    sync();
    chk("slot1_addr", 32'(loader_addr), 32'h28000);
    chk("slot1_data", 32'(loader_data), 32'h11);
    ioctl_index = 8'd9;
    step(1'b0, 1'b1, 25'h0, 8'h22);
    sync();
    chk("slot9_we",   32'(loader_we), 32'h1);
    chk("slot9_addr", 32'(loader_addr), 32'h0);
    chk("slot9_data", 32'(loader_data), 32'h22);
    ioctl_index = 8'hff;
    step(1'b0, 1'b1, 25'h5, 8'h33);
    sync();
    chk("skip_we",    32'(loader_we), 32'h0);
    chk("skip_busy",  32'(busy), 32'h1);
    chk("slot_bytes", 32'(bytes_written), 32'h2);
    ioctl_download = 1'b0;
    idle();
    chk("skip_busy_low", 32'(busy), 32'h0);

    // Full FIFO with a pop in the same cycle
    ioctl_download = 1'b1; ioctl_index = 8'd0;
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 25'(i), 8'(8'h60 + i));
    chk("full_ovf0", 32'(overflow), 32'h0);
    chk("full_bytes_cleared", 32'(bytes_written), 32'h0);
    step(1'b1, 1'b1, 25'h50, 8'h99);
    chk("fp_ovf",  32'(overflow), 32'h0);
    chk("fp_data", 32'(loader_data), 32'h60);
    step(1'b0, 1'b1, 25'h51, 8'hAA);
    chk("fp_still_full", 32'(overflow), 32'h1);
    ioctl_download = 1'b0;
    idle();
    chk("fp_busy_drain", 32'(busy), 32'h1);
    for (int i = 1; i < 8; i++) begin
      sync();
      chk("fp_drain_data", 32'(loader_data), 32'(8'h60 + i));
      chk("fp_drain_addr", 32'(loader_addr), 32'(25'h80000 + i));
      idle();
    end
    sync();
    chk("fp_last_data", 32'(loader_data), 32'h99);
    chk("fp_last_addr", 32'(loader_addr), 32'h80050);
    idle();
    sync();
    chk("fp_end_we",    32'(loader_we), 32'h0);
    chk("fp_bytes",     32'(bytes_written), 32'd9);
    chk("fp_end_busy",  32'(busy), 32'h0);

    // Burst overflow
    ioctl_download = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1, 25'(i), 8'(8'h40 + i));
      if (i == 0) chk("burst_ovf_cleared", 32'(overflow), 32'h0);
      if (i == 7) chk("burst_ovf_at8", 32'(overflow), 32'h0);
    end
    chk("burst_ovf", 32'(overflow), 32'h1);
    ioctl_download = 1'b0;
    idle();
    for (int i = 0; i < 8; i++) begin
      sync();
      chk("burst_data", 32'(loader_data), 32'(8'h40 + i));
      chk("burst_addr", 32'(loader_addr), 32'(25'h80000 + i));
      idle();
    end
    sync();
    chk("burst_end_we", 32'(loader_we), 32'h0);
    chk("burst_bytes",  32'(bytes_written), 32'd8);

    // Range check
    ioctl_download = 1'b1;
    step(1'b0, 1'b1, 25'h20000, 8'h77);
    chk("rng_set",      32'(range_err), 32'h1);
    chk("rng_ovf_clr",  32'(overflow), 32'h0);
    sync();
    chk("rng_no_write", 32'(loader_we), 32'h0);
    step(1'b0, 1'b1, 25'h1FFFF, 8'h78);
    sync();
    chk("rng_edge_we",   32'(loader_we), 32'h1);
    chk("rng_edge_addr", 32'(loader_addr), 32'h9FFFF);
    chk("rng_sticky",    32'(range_err), 32'h1);
    ioctl_download = 1'b0;
    idle();
    ioctl_download = 1'b1;
    idle();
    chk("rng_cleared",   32'(range_err), 32'h0);
    chk("rng_bytes_clr", 32'(bytes_written), 32'h0);

    // Reset during a drain
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 25'(25'h100 + i), 8'(i));
    sync();
    chk("rmd_we_pre", 32'(loader_we), 32'h1);
    step(1'b0, 1'b1, 25'h105, 8'h05);
    ioctl_download = 1'b0;
    reset = 1'b1;
    idle();
    reset = 1'b0;
    chk("rmd_we",    32'(loader_we), 32'h0);
    chk("rmd_busy",  32'(busy), 32'h0);
    chk("rmd_crr",   32'(core_reset_req), 32'h0);
    chk("rmd_bytes", 32'(bytes_written), 32'h0);
    sync();
    chk("rmd_no_write", 32'(loader_we), 32'h0);
    chk("rmd_busy2",    32'(busy), 32'h0);
    chk("rmd_done",     32'(done), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
